// File: rtl/fma_operand_loader_if.sv
// fma_operand_loader_if: command, BRAM read and buffer handshake bundle
// master = loader side, slave = controller/BRAM/buffer side
interface fma_operand_loader_if #(
  parameter int FMA_COUNT  = 2,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                         cmd_valid_in;
  logic                         cmd_ready_out;
  logic [ADDR_WIDTH-1:0]        cmd_a_base_in;
  logic [ADDR_WIDTH-1:0]        cmd_b_base_in;
  logic [ADDR_WIDTH-1:0]        cmd_c_base_in;
  logic                         cmd_c_en_in;
  logic [ADDR_WIDTH-1:0]        bram_addr_out;
  logic [WIDTH-1:0]             bram_data_in;
  logic                         buf_fire_in;
  logic [FMA_COUNT*3*WIDTH-1:0] abc_out;
  logic [FMA_COUNT*3-1:0]       abc_valid_out;
  logic                         busy_out;

  modport master (
    input  cmd_valid_in, cmd_a_base_in, cmd_b_base_in,
    input  cmd_c_base_in, cmd_c_en_in, bram_data_in,
    input  buf_fire_in,
    output cmd_ready_out, bram_addr_out, abc_out,
    output abc_valid_out, busy_out
  );

  modport slave (
    output cmd_valid_in, cmd_a_base_in, cmd_b_base_in,
    output cmd_c_base_in, cmd_c_en_in, bram_data_in,
    output buf_fire_in,
    input  cmd_ready_out, bram_addr_out, abc_out,
    input  abc_valid_out, busy_out
  );
endinterface

// File: rtl/fma_operand_loader.sv
// fma_operand_loader: reads a/b/c per FMA from BRAM, emits paired beats
// FMA_LOADER_B_BROADCAST_EN: read b once and reuse it for every slot
module fma_operand_loader #(
  parameter int FMA_COUNT    = 2,
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 11,
  parameter int BRAM_LATENCY = 2
) (
  input logic clk_in,
  input logic rst_in,
  fma_operand_loader_if.master bus
);
  localparam int IW = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;
  localparam int SW = 3 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(FMA_COUNT - 1);
  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_ACK} state_t;

  state_t state, state_nxt;
  logic [IW-1:0] fma, fma_nxt;
  logic [1:0] op, op_nxt;
  logic [1:0] first_op;
  logic issue, accept;

  logic [ADDR_WIDTH-1:0] a_base, b_base, c_base;
  logic [ADDR_WIDTH-1:0] base;
  logic c_en;

  logic          tag_v   [BRAM_LATENCY];
  logic [IW-1:0] tag_idx [BRAM_LATENCY];
  logic [1:0]    tag_op  [BRAM_LATENCY];
  logic          ret_v;
  logic [IW-1:0] ret_idx;
  logic [1:0]    ret_op;
  logic          pipe_busy;

  logic [WIDTH-1:0] c_lat;
`ifdef FMA_LOADER_B_BROADCAST_EN
  logic [WIDTH-1:0] b_lat;
`else
  logic [WIDTH-1:0] a_lat;
`endif
  logic beat;
  logic [WIDTH-1:0] beat_a, beat_b;
  logic [FMA_COUNT*SW-1:0] abc_q;
  logic [FMA_COUNT*3-1:0] vld_q;

  assign accept   = (state == IDLE) && bus.cmd_valid_in;
  assign issue    = (state == ISSUE);
  assign first_op = c_en ? OP_C : OP_A;
  assign ret_v    = tag_v[BRAM_LATENCY-1];
  assign ret_idx  = tag_idx[BRAM_LATENCY-1];
  assign ret_op   = tag_op[BRAM_LATENCY-1];

  assign bus.cmd_ready_out = (state == IDLE);
  assign bus.busy_out      = (state != IDLE);
  assign bus.abc_out       = abc_q;
  assign bus.abc_valid_out = vld_q;

  // state and issue-cursor registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      fma   <= '0;
      op    <= OP_A;
    end else begin
      state <= state_nxt;
      fma   <= fma_nxt;
      op    <= op_nxt;
    end
  end

  // next state and read sequencing: c, a, b per slot
  always_comb begin
    state_nxt = state;
    fma_nxt   = fma;
    op_nxt    = op;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid_in) begin
          state_nxt = ISSUE;
          fma_nxt   = '0;
`ifdef FMA_LOADER_B_BROADCAST_EN
          op_nxt    = OP_B;
`else
          op_nxt    = bus.cmd_c_en_in ? OP_C : OP_A;
`endif
        end
      end
      ISSUE: begin
        if (op == OP_C) begin
          op_nxt = OP_A;
`ifdef FMA_LOADER_B_BROADCAST_EN
        end else if (op == OP_B) begin
          op_nxt = first_op;
`else
        end else if (op == OP_A) begin
          op_nxt = OP_B;
`endif
        end else if (fma == LAST) begin
          state_nxt = DRAIN;
        end else begin
          fma_nxt = fma + 1'b1;
          op_nxt  = first_op;
        end
      end
      DRAIN: begin
        if (!pipe_busy) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.buf_fire_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // read address for the operand being issued, zero otherwise
  always_comb begin
    base = a_base;
    unique case (1'b1)
      op == OP_B: base = b_base;
      op == OP_C: base = c_base;
      default:    base = a_base;
    endcase
    bus.bram_addr_out = issue ? base + ADDR_WIDTH'(fma) : '0;
  end

  // command latch
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
      c_en   <= 1'b0;
    end else if (accept) begin
      a_base <= bus.cmd_a_base_in;
      b_base <= bus.cmd_b_base_in;
      c_base <= bus.cmd_c_base_in;
      c_en   <= bus.cmd_c_en_in;
    end
  end

  // tag shift register aligned with BRAM read latency
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < BRAM_LATENCY; k++) begin
        tag_v[k]   <= 1'b0;
        tag_idx[k] <= '0;
        tag_op[k]  <= OP_A;
      end
    end else begin
      tag_v[0]   <= issue;
      tag_idx[0] <= fma;
      tag_op[0]  <= op;
      for (int k = 1; k < BRAM_LATENCY; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_idx[k] <= tag_idx[k-1];
        tag_op[k]  <= tag_op[k-1];
      end
    end
  end

  // any read still in flight
  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < BRAM_LATENCY; k++) begin
      pipe_busy = pipe_busy | tag_v[k];
    end
  end

  // operand latches for returns that do not complete a beat
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      c_lat <= '0;
`ifdef FMA_LOADER_B_BROADCAST_EN
      b_lat <= '0;
`else
      a_lat <= '0;
`endif
    end else if (accept) begin
      c_lat <= '0;
    end else if (ret_v) begin
      if (ret_op == OP_C) c_lat <= bus.bram_data_in;
`ifdef FMA_LOADER_B_BROADCAST_EN
      if (ret_op == OP_B) b_lat <= bus.bram_data_in;
`else
      if (ret_op == OP_A) a_lat <= bus.bram_data_in;
`endif
    end
  end

  // beat trigger: the last operand of a slot returning
  always_comb begin
`ifdef FMA_LOADER_B_BROADCAST_EN
    beat   = ret_v && (ret_op == OP_A);
    beat_a = bus.bram_data_in;
    beat_b = b_lat;
`else
    beat   = ret_v && (ret_op == OP_B);
    beat_a = a_lat;
    beat_b = bus.bram_data_in;
`endif
  end

  // one-cycle beat register into the buffer layout
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      abc_q <= '0;
      vld_q <= '0;
    end else begin
      abc_q <= '0;
      vld_q <= '0;
      if (beat) begin
        for (int s = 0; s < FMA_COUNT; s++) begin
          if (ret_idx == IW'(s)) begin
            abc_q[s*SW +: SW] <= {c_lat, beat_b, beat_a};
            vld_q[s*3 +: 3]   <= {c_en, 2'b11};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fma_operand_loader.sv
// tb_fma_operand_loader: directed and random commands vs operand model
// honours FMA_LOADER_B_BROADCAST_EN the same way as the design
module tb_fma_operand_loader;
  localparam int FC   = 2;
  localparam int W    = 16;
  localparam int AW   = 11;
  localparam int L    = 2;
  localparam int MASK = (1 << AW) - 1;
  localparam int SW   = 3 * W;

  typedef struct packed {
    logic [FC*SW-1:0] abc;
    logic [FC*3-1:0]  v;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  int    exp_rd[$];
  beat_t exp_bt[$];

  logic [W-1:0] mem [1 << AW];
  logic [W-1:0] rd_pipe [L];

  fma_operand_loader_if #(
    .FMA_COUNT(FC), .WIDTH(W), .ADDR_WIDTH(AW)
  ) bus ();

  fma_operand_loader #(
    .FMA_COUNT(FC), .WIDTH(W),
    .ADDR_WIDTH(AW), .BRAM_LATENCY(L)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus.bram_addr_out];
    for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.bram_data_in = rd_pipe[L-1];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int a, input int b,
                       input int c, input bit cen);
    logic [W-1:0] av, bv, cv;
    beat_t e;
    exp_rd.delete();
    exp_bt.delete();
`ifdef FMA_LOADER_B_BROADCAST_EN
    exp_rd.push_back(b & MASK);
`endif
    for (int i = 0; i < FC; i++) begin
      if (cen) exp_rd.push_back((c + i) & MASK);
      exp_rd.push_back((a + i) & MASK);
`ifndef FMA_LOADER_B_BROADCAST_EN
      exp_rd.push_back((b + i) & MASK);
`endif
    end
    for (int i = 0; i < FC; i++) begin
      e = '0;
      av = mem[(a + i) & MASK];
`ifdef FMA_LOADER_B_BROADCAST_EN
      bv = mem[b & MASK];
`else
      bv = mem[(b + i) & MASK];
`endif
      cv = cen ? mem[(c + i) & MASK] : '0;
      e.abc[i*SW +: SW] = {cv, bv, av};
      e.v[i*3 +: 3] = {cen, 2'b11};
      exp_bt.push_back(e);
    end
  endtask

  // entered just after a negedge in cycle 0 with the loader idle
  task automatic run_cmd(input int a, input int b,
                         input int c, input bit cen);
    int nrd;
    int last;
    beat_t got;
    model(a, b, c, cen);
    nrd = exp_rd.size();
    last = -1;
    chk("ready_before_cmd", bus.cmd_ready_out, 1);
    bus.cmd_a_base_in = AW'(a);
    bus.cmd_b_base_in = AW'(b);
    bus.cmd_c_base_in = AW'(c);
    bus.cmd_c_en_in = cen;
    bus.cmd_valid_in = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid_in = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc <= nrd)
        chk($sformatf("rd_addr%0d", cyc - 1),
            bus.bram_addr_out, exp_rd[cyc-1]);
      if (bus.abc_valid_out !== '0) begin
        if (exp_bt.size() == 0) begin
          chk("extra_beat", bus.abc_valid_out, 0);
        end else begin
          got = exp_bt.pop_front();
          chk("beat_abc", bus.abc_out, got.abc);
          chk("beat_vld", bus.abc_valid_out, got.v);
          last = cyc;
        end
      end else begin
        chk("quiet_abc", bus.abc_out, 0);
      end
      bus.buf_fire_in = (cyc == 2) || (cyc == nrd + 2);
    end
    bus.buf_fire_in = 1'b0;
    chk("beats_left", exp_bt.size(), 0);
    chk("last_beat_cycle", last, nrd + L + 1);
    chk("wait_ack", {bus.cmd_ready_out, bus.busy_out}, 2'b01);
  endtask

  task automatic ack();
    bus.buf_fire_in = 1'b1;
    @(posedge clk);
    #1 bus.buf_fire_in = 1'b0;
    @(negedge clk);
    chk("ready_after_ack", bus.cmd_ready_out, 1);
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_ready"}, bus.cmd_ready_out, 1);
    chk({tag, "_rest"}, {bus.busy_out, bus.bram_addr_out,
                         bus.abc_valid_out, bus.abc_out}, '0);
  endtask

  initial begin
    for (int x = 0; x < (1 << AW); x++) mem[x] = W'(x);
    bus.cmd_valid_in = 1'b0;
    bus.cmd_a_base_in = '0;
    bus.cmd_b_base_in = '0;
    bus.cmd_c_base_in = '0;
    bus.cmd_c_en_in = 1'b0;
    bus.buf_fire_in = 1'b0;

    repeat (3) @(negedge clk);
    chk_rst_vals("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_rst_vals("post_reset");
    end

    run_cmd('h10, 'h20, 'h30, 1'b1);
    ack();
    run_cmd('h10, 'h20, 'h30, 1'b0);

    bus.cmd_a_base_in = AW'('h40);
    bus.cmd_b_base_in = AW'('h50);
    bus.cmd_c_base_in = AW'('h60);
    bus.cmd_c_en_in = 1'b1;
    bus.cmd_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_not_taken",
          {bus.cmd_ready_out, bus.busy_out}, 2'b01);
    end
    ack();
    run_cmd('h40, 'h50, 'h60, 1'b1);
    ack();

    bus.cmd_a_base_in = AW'('h10);
    bus.cmd_b_base_in = AW'('h20);
    bus.cmd_c_base_in = AW'('h30);
    bus.cmd_c_en_in = 1'b1;
    bus.cmd_valid_in = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_rst_vals("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_beat_after_rst",
          {bus.busy_out, bus.abc_valid_out}, '0);
    end
    run_cmd('h10, 'h20, 'h30, 1'b1);
    ack();

    run_cmd('h7FF, 'h123, 'h7FF, 1'b1);
    ack();

    for (int x = 0; x < (1 << AW); x++) mem[x] = W'($urandom);
    for (int n = 0; n < 6; n++) begin
      run_cmd(int'($urandom_range(0, MASK)),
              int'($urandom_range(0, MASK)),
              int'($urandom_range(0, MASK)),
              1'($urandom_range(0, 1)));
      ack();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
